// File: rtl/mips_pc_if.sv
// Fetch-stage bus between decode/execute (master) and the program-counter unit (slave).
// Carries the control-transfer requests in one direction and the PC-derived outputs back.
interface mips_pc_if;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        jr_en;
  logic [31:0] jr_target;
  logic [31:0] instr_address;
  logic [31:0] link_address;
  logic        active;
  logic        in_delay_slot;

  modport master (
    output branch_taken, branch_offset, jump_en, jump_index, jr_en, jr_target,
    input  instr_address, link_address, active, in_delay_slot
  );

  modport slave (
    input  branch_taken, branch_offset, jump_en, jump_index, jr_en, jr_target,
    output instr_address, link_address, active, in_delay_slot
  );
endinterface

// File: rtl/mips_pc_unit.sv
// Program counter and fetch sequencing for the Harvard MIPS CPU, with branch-delay-slot
// redirects, link-address generation and halt-on-fetch-of-zero.
module mips_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDRESS = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clk_enable,
  mips_pc_if.slave  bus
);

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_DELAY  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  logic [1:0]  state_q,  state_d;
  logic [31:0] pc_q,     pc_d;
  logic [31:0] pending_q, pending_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target_aligned;
  logic        req_any;
  logic [31:0] req_target;

  // Candidate targets are all relative to the delay-slot address, p+4.
  always_comb begin
    pc_plus4          = pc_q + 32'd4;
    branch_target     = pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    jump_target       = {pc_plus4[31:28], bus.jump_index, 2'b00};
    jr_target_aligned = {bus.jr_target[31:2], 2'b00};
  end

  always_comb begin
    req_any = bus.jr_en | bus.jump_en | bus.branch_taken;
    if (bus.jr_en) begin
      req_target = jr_target_aligned;
    end else if (bus.jump_en) begin
      req_target = jump_target;
    end else begin
      req_target = branch_target;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;

    case (state_q)
      ST_RUN: begin
        pc_d = pc_plus4;
        if (req_any) begin
          pending_d = req_target;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY: begin
        // A control transfer sitting in the delay slot is deliberately dropped.
        pc_d    = pending_q;
        state_d = ST_RUN;
      end
      default: begin
        pc_d    = HALT_ADDRESS;
        state_d = ST_HALTED;
      end
    endcase

    // Fetching the halt address, by redirect or by wrap-around, stops the CPU.
    if (state_q != ST_HALTED && pc_d == HALT_ADDRESS) begin
      state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      pending_q <= 32'd0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

  assign bus.instr_address = pc_q;
  assign bus.link_address  = pc_q + 32'd8;
  assign bus.active        = (state_q != ST_HALTED);
  assign bus.in_delay_slot = (state_q == ST_DELAY);

endmodule

// File: tb/tb_mips_pc_unit.sv
// Directed self-checking bench for mips_pc_unit: reset sequencing, redirects, priority,
// delay-slot behaviour, clock enable, mid-redirect reset and halting.
module tb_mips_pc_unit;

  logic clk;
  logic reset;
  logic clk_enable;
  int   checks;
  int   errors;

  mips_pc_if pc_if ();

  mips_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (pc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_requests();
    pc_if.branch_taken  = 1'b0;
    pc_if.branch_offset = 16'h0000;
    pc_if.jump_en       = 1'b0;
    pc_if.jump_index    = 26'h0;
    pc_if.jr_en         = 1'b0;
    pc_if.jr_target     = 32'h0;
  endtask

  task automatic apply_reset();
    clear_requests();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_requests();
    clk_enable = 1'b1;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (pc_if.instr_address !== 32'hBFC00000) begin
      errors++; $display("FAIL reset_pc0 got %h expected %h", pc_if.instr_address, 32'hBFC00000);
    end
    checks++;
    if (pc_if.active !== 1'b1 || pc_if.in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL reset_flags got active=%b ids=%b expected active=1 ids=0",
                         pc_if.active, pc_if.in_delay_slot);
    end
    checks++;
    if (pc_if.link_address !== 32'hBFC00008) begin
      errors++; $display("FAIL reset_link got %h expected %h", pc_if.link_address, 32'hBFC00008);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00004) begin
      errors++; $display("FAIL reset_pc1 got %h expected %h", pc_if.instr_address, 32'hBFC00004);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00008 || pc_if.link_address !== 32'hBFC00010) begin
      errors++; $display("FAIL reset_pc2 got pc=%h link=%h expected pc=%h link=%h",
                         pc_if.instr_address, pc_if.link_address, 32'hBFC00008, 32'hBFC00010);
    end
  endtask

  // Continues from PC 0xBFC00008 left by test_reset.
  task automatic test_branch();
    pc_if.branch_taken  = 1'b1;
    pc_if.branch_offset = 16'h0002;
    checks++;
    if (pc_if.link_address !== 32'hBFC00010) begin
      errors++; $display("FAIL branch_link got %h expected %h", pc_if.link_address, 32'hBFC00010);
    end
    step();
    clear_requests();
    checks++;
    if (pc_if.instr_address !== 32'hBFC0000C || pc_if.in_delay_slot !== 1'b1) begin
      errors++; $display("FAIL branch_slot got pc=%h ids=%b expected pc=%h ids=1",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC0000C);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00014 || pc_if.in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL branch_target got pc=%h ids=%b expected pc=%h ids=0",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00014);
    end
  endtask

  task automatic test_negative_branch();
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00010) begin
      errors++; $display("FAIL negbr_start got %h expected %h", pc_if.instr_address, 32'hBFC00010);
    end
    pc_if.branch_taken  = 1'b1;
    pc_if.branch_offset = 16'hFFFF;
    step();
    // Requests during the delay slot must be ignored.
    pc_if.branch_taken  = 1'b1;
    pc_if.branch_offset = 16'h0040;
    pc_if.jump_en       = 1'b1;
    pc_if.jump_index    = 26'h0000123;
    pc_if.jr_en         = 1'b1;
    pc_if.jr_target     = 32'h12345678;
    checks++;
    if (pc_if.instr_address !== 32'hBFC00014 || pc_if.in_delay_slot !== 1'b1) begin
      errors++; $display("FAIL negbr_slot got pc=%h ids=%b expected pc=%h ids=1",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00014);
    end
    step();
    clear_requests();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00010 || pc_if.in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL negbr_target got pc=%h ids=%b expected pc=%h ids=0",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00010);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00014) begin
      errors++; $display("FAIL negbr_resume got %h expected %h", pc_if.instr_address, 32'hBFC00014);
    end
  endtask

  task automatic test_jump_priority();
    apply_reset();
    pc_if.jump_en       = 1'b1;
    pc_if.jump_index    = 26'h0000010;
    pc_if.branch_taken  = 1'b1;
    pc_if.branch_offset = 16'h0100;
    step();
    clear_requests();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00004 || pc_if.in_delay_slot !== 1'b1) begin
      errors++; $display("FAIL jump_slot got pc=%h ids=%b expected pc=%h ids=1",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00004);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'hB0000040) begin
      errors++; $display("FAIL jump_target got %h expected %h", pc_if.instr_address, 32'hB0000040);
    end

    apply_reset();
    pc_if.jr_en         = 1'b1;
    pc_if.jr_target     = 32'hBFC00103;
    pc_if.jump_en       = 1'b1;
    pc_if.jump_index    = 26'h0000010;
    pc_if.branch_taken  = 1'b1;
    pc_if.branch_offset = 16'h0100;
    step();
    clear_requests();
    step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00100) begin
      errors++; $display("FAIL jr_priority got %h expected %h", pc_if.instr_address, 32'hBFC00100);
    end
  endtask

  task automatic test_clk_enable();
    apply_reset();
    pc_if.branch_taken  = 1'b1;
    pc_if.branch_offset = 16'h0004;
    step();
    clear_requests();
    clk_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc_if.instr_address !== 32'hBFC00004 || pc_if.in_delay_slot !== 1'b1) begin
        errors++; $display("FAIL ce_hold%0d got pc=%h ids=%b expected pc=%h ids=1",
                           i, pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00004);
      end
    end
    clk_enable = 1'b1;
    step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00014 || pc_if.in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL ce_resume got pc=%h ids=%b expected pc=%h ids=0",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00014);
    end
  endtask

  task automatic test_reset_mid_delay();
    apply_reset();
    pc_if.branch_taken  = 1'b1;
    pc_if.branch_offset = 16'h0004;
    step();
    clear_requests();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (pc_if.instr_address !== 32'hBFC00000 || pc_if.in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL rst_delay got pc=%h ids=%b expected pc=%h ids=0",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00000);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00004 || pc_if.in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL rst_no_redirect got pc=%h ids=%b expected pc=%h ids=0",
                         pc_if.instr_address, pc_if.in_delay_slot, 32'hBFC00004);
    end
  endtask

  task automatic test_jr_halt();
    apply_reset();
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00018) begin
      errors++; $display("FAIL halt_start got %h expected %h", pc_if.instr_address, 32'hBFC00018);
    end
    pc_if.jr_en     = 1'b1;
    pc_if.jr_target = 32'h00000000;
    step();
    clear_requests();
    checks++;
    if (pc_if.instr_address !== 32'hBFC0001C || pc_if.active !== 1'b1) begin
      errors++; $display("FAIL halt_slot got pc=%h active=%b expected pc=%h active=1",
                         pc_if.instr_address, pc_if.active, 32'hBFC0001C);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'h00000000 || pc_if.active !== 1'b0 ||
        pc_if.link_address !== 32'h00000008) begin
      errors++; $display("FAIL halt_enter got pc=%h active=%b link=%h expected pc=0 active=0 link=8",
                         pc_if.instr_address, pc_if.active, pc_if.link_address);
    end
    for (int i = 0; i < 5; i++) begin
      pc_if.branch_taken  = 1'($urandom_range(0, 1));
      pc_if.branch_offset = 16'($urandom);
      pc_if.jump_en       = 1'($urandom_range(0, 1));
      pc_if.jump_index    = 26'($urandom);
      pc_if.jr_en         = 1'($urandom_range(0, 1));
      pc_if.jr_target     = 32'($urandom) | 32'h100;
      step();
      checks++;
      if (pc_if.instr_address !== 32'h00000000 || pc_if.active !== 1'b0) begin
        errors++; $display("FAIL halt_hold%0d got pc=%h active=%b expected pc=0 active=0",
                           i, pc_if.instr_address, pc_if.active);
      end
    end
    apply_reset();
    checks++;
    if (pc_if.instr_address !== 32'hBFC00000 || pc_if.active !== 1'b1) begin
      errors++; $display("FAIL halt_exit got pc=%h active=%b expected pc=%h active=1",
                         pc_if.instr_address, pc_if.active, 32'hBFC00000);
    end
  endtask

  task automatic test_wrap_halt();
    apply_reset();
    pc_if.jr_en     = 1'b1;
    pc_if.jr_target = 32'hFFFFFFF9;
    step();
    clear_requests();
    step();
    checks++;
    if (pc_if.instr_address !== 32'hFFFFFFF8) begin
      errors++; $display("FAIL wrap_target got %h expected %h", pc_if.instr_address, 32'hFFFFFFF8);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'hFFFFFFFC || pc_if.link_address !== 32'h00000004 ||
        pc_if.active !== 1'b1) begin
      errors++; $display("FAIL wrap_last got pc=%h link=%h active=%b expected pc=%h link=4 active=1",
                         pc_if.instr_address, pc_if.link_address, pc_if.active, 32'hFFFFFFFC);
    end
    step();
    checks++;
    if (pc_if.instr_address !== 32'h00000000 || pc_if.active !== 1'b0) begin
      errors++; $display("FAIL wrap_halt got pc=%h active=%b expected pc=0 active=0",
                         pc_if.instr_address, pc_if.active);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clk_enable = 1'b1;
    reset      = 1'b1;
    clear_requests();
    @(negedge clk);
    test_reset();
    test_branch();
    test_negative_branch();
    test_jump_priority();
    test_clk_enable();
    test_reset_mid_delay();
    test_jr_halt();
    test_wrap_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_pc_unit.md
# mips_pc_unit

Program-counter and fetch-sequencing stage of the Harvard MIPS CPU, directly upstream of instruction fetch: it drives `instr_address` and resolves branch/jump redirects with MIPS branch-delay-slot semantics. The decode/execute logic reports each control-transfer decision in the cycle its instruction executes. This block computes the target, lets the delay-slot instruction fetch, then redirects. It also produces the link address for `*AL`/`JALR` and the CPU `active` flag; fetching address 0x00000000 halts the CPU.

## Interface
- `RESET_VECTOR`, 32'hBFC00000, PC value loaded on reset
- `HALT_ADDRESS`, 32'h00000000, PC value that halts the CPU
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — synchronous, active-high
- `clk_enable` input 1 — when low, all state holds
- `branch_taken` input 1 — conditional branch at current PC resolved taken
- `branch_offset` input 16 — branch immediate, instruction bits [15:0]
- `jump_en` input 1 — J/JAL at current PC
- `jump_index` input 26 — instruction bits [25:0]
- `jr_en` input 1 — JR/JALR at current PC
- `jr_target` input 32 — rs register value
- `instr_address` output 32 — current fetch PC
- `link_address` output 32 — current PC + 8, combinational
- `active` output 1 — high while running, low once halted
- `in_delay_slot` output 1 — current PC is a delay-slot instruction

## Operation
- State machine:
  - RUN: no redirect pending.
  - DELAY: redirect pending; the current PC is the delay slot.
  - HALTED: terminal.
- Reset: PC = RESET_VECTOR, state RUN, `pending_target` = 0, `active` = 1, `in_delay_slot` = 0.
- Target arithmetic (p = current PC, all mod 2^32):
  - branch: (p+4) + (sign_extend(branch_offset) << 2)
  - jump: {(p+4)[31:28], jump_index, 2'b00}
  - jr: {jr_target[31:2], 2'b00}, low bits silently cleared
- Priority when several requests are high: jr_en > jump_en > branch_taken.
- RUN, request present: PC <= p+4, `pending_target` <= target, go to DELAY.
- RUN, no request: PC <= p+4.
- DELAY: PC <= `pending_target`, go to RUN. Any request during DELAY (branch in delay slot) is ignored.
- Halt: on any edge where the next PC equals HALT_ADDRESS, the PC loads it and the state goes to HALTED. In HALTED, PC is frozen at HALT_ADDRESS, `active` = 0 and requests are ignored; only reset leaves HALTED.
- `in_delay_slot` = (state == DELAY).
- `link_address` = `instr_address` + 8 in every state.

## Timing
- Single-cycle fetch: `instr_address` is registered and valid from the edge that loads it. The fetch memory returns `instr_readdata` combinationally in the same cycle.
- Redirect latency:
  - request in cycle n (PC p)
  - cycle n+1: PC = p+4 (delay slot)
  - cycle n+2: PC = target
- `active` falls on the same edge that loads HALT_ADDRESS into the PC.
- `clk_enable` = 0: PC, state and `pending_target` hold; outputs unchanged.
- Reset has priority over `clk_enable` and over every state, including mid-DELAY. A pending redirect is discarded.
- PC wrap at 0xFFFFFFFC + 4 = 0x00000000 is a halt.

## Test plan
- Reset sequencing: hold `reset` = 1 for 2 cycles, release, no requests → PC 0xBFC00000, 0xBFC00004, 0xBFC00008 on successive cycles; `active` = 1; `link_address` = PC+8.
- Taken branch with delay slot: at PC 0xBFC00008, `branch_taken` = 1, offset 0x0002 → next PC 0xBFC0000C with `in_delay_slot` = 1, then 0xBFC00014. `link_address` sampled at 0xBFC00008 = 0xBFC00010.
- JR halt: at PC 0xBFC00018, `jr_en` = 1, `jr_target` = 0 → PC 0xBFC0001C, then 0x00000000 with `active` = 0. PC stays 0 for 5 further cycles despite random requests.
- Jump and priority: at PC 0xBFC00000, `jump_en` = 1, index 0x0000010, with `branch_taken` = 1 also high → target 0xB0000040 after the delay slot. With `jr_en` = 1, `jr_target` 0xBFC00103 also high → target 0xBFC00100.
- Branch in delay slot ignored; negative offset: branch at 0xBFC00010, offset 0xFFFF → target 0xBFC00010. A request during the DELAY cycle is ignored.
- `clk_enable` and reset mid-operation:
  - drop `clk_enable` for 3 cycles during DELAY → PC and `in_delay_slot` frozen, redirect completes after re-enable
  - assert `reset` during DELAY → PC 0xBFC00000, `in_delay_slot` = 0, no redirect taken
